// File: rtl/lighthouse_sample_arbiter_pkg.sv
// Shared constants for the lighthouse sample arbiter: register map, status
// layout and FIFO entry format.
package lighthouse_sample_arbiter_pkg;

  localparam int MAX_SENSORS = 16;
  localparam int ID_W        = 4;
  localparam int DATA_W      = 32;
  localparam int ENTRY_W     = ID_W + DATA_W;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_HEAD_ID = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_MASK    = 3'd3;
  localparam logic [2:0] ADDR_CTRL    = 3'd4;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  localparam int ST_EMPTY_BIT     = 13;
  localparam int ST_FULL_BIT      = 14;
  localparam int ST_UNDERFLOW_BIT = 15;
  localparam int ST_OVERRUN_LSB   = 16;

  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  function automatic logic [31:0] pack_status(input logic [MAX_SENSORS-1:0] overrun,
                                              input logic underflow,
                                              input logic full,
                                              input logic empty,
                                              input logic [7:0] count);
    logic [31:0] s;
    s = '0;
    s[7:0] = count;
    s[ST_EMPTY_BIT] = empty;
    s[ST_FULL_BIT] = full;
    s[ST_UNDERFLOW_BIT] = underflow;
    s[ST_OVERRUN_LSB +: MAX_SENSORS] = overrun;
    return s;
  endfunction

endpackage

// File: rtl/lighthouse_sample_arbiter_fifo.sv
// Synchronous FIFO of {id,data} entries with flush; pop and push together
// while full is legal and keeps the count unchanged.
module lighthouse_sample_fifo
  import lighthouse_sample_arbiter_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = ENTRY_W,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lighthouse_sample_arbiter.sv
// Captures sensor update pulses, round-robin arbitrates one per clock into a
// sample FIFO, and exposes the FIFO plus status/control over Avalon-MM.
module lighthouse_sample_arbiter
  import lighthouse_sample_arbiter_pkg::*;
#(
  parameter int NUM_SENSORS = 9,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [2:0]                    address,
  input  logic                          write,
  input  logic [31:0]                   writedata,
  input  logic                          read,
  output logic [31:0]                   readdata,
  output logic                          waitrequest,
  input  logic [NUM_SENSORS*DATA_W-1:0] sensor_data_i,
  input  logic [NUM_SENSORS-1:0]        sensor_valid_i
);

  localparam logic [MAX_SENSORS-1:0] RESET_MASK = MAX_SENSORS'((1 << NUM_SENSORS) - 1);
  localparam logic [ID_W-1:0]        LAST_INIT  = ID_W'(NUM_SENSORS - 1);

  logic [MAX_SENSORS-1:0] mask;
  logic [NUM_SENSORS-1:0] pending;
  logic [NUM_SENSORS-1:0] overrun;
  logic [NUM_SENSORS-1:0] capture;
  logic [DATA_W-1:0]      pending_data [NUM_SENSORS];
  logic                   underflow;
  logic [ID_W-1:0]        last_grant;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_any;
  logic                   grant_fire;
  logic                   mask_wr;
  logic                   ctrl_wr;
  logic                   flush;
  logic                   clear_flags;
  logic                   data_rd;
  logic                   pop;
  logic                   can_push;
  logic [ENTRY_W-1:0]     fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [MAX_SENSORS-1:0] overrun_ext;
  logic [7:0]             count8;
  logic                   unused_wdata;

  assign waitrequest  = 1'b0;
  assign unused_wdata = ^writedata[31:16];

  assign mask_wr     = write && (address == ADDR_MASK);
  assign ctrl_wr     = write && (address == ADDR_CTRL);
  assign flush       = ctrl_wr && writedata[CTRL_FLUSH_BIT];
  assign clear_flags = ctrl_wr && writedata[CTRL_CLEAR_BIT];
  assign data_rd     = read && (address == ADDR_DATA);
  assign pop         = data_rd && !fifo_empty;
  assign can_push    = !fifo_full || pop;
  // A flush drops anything pushed that cycle, so hold the grant and keep the sample pending.
  assign grant_fire  = grant_any && can_push && !flush;
  assign capture     = sensor_valid_i & mask[NUM_SENSORS-1:0];

  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_SENSORS; k++) begin
      idx = (int'(last_grant) + k) % NUM_SENSORS;
      if (!grant_any && pending[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending    <= '0;
      overrun    <= '0;
      underflow  <= 1'b0;
      mask       <= RESET_MASK;
      last_grant <= LAST_INIT;
    end else begin
      if (clear_flags) begin
        overrun   <= '0;
        underflow <= 1'b0;
      end
      if (data_rd && fifo_empty) underflow <= 1'b1;
      if (grant_fire) last_grant <= grant_idx;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (grant_fire && grant_idx == ID_W'(i)) pending[i] <= 1'b0;
        // New data arriving on the granted sensor simply re-arms it; not an overrun.
        if (capture[i]) begin
          pending[i] <= 1'b1;
          if (pending[i] && !(grant_fire && grant_idx == ID_W'(i))) overrun[i] <= 1'b1;
        end
        if (mask_wr && !writedata[i]) pending[i] <= 1'b0;
      end
      if (mask_wr) mask <= writedata[MAX_SENSORS-1:0];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (capture[i]) pending_data[i] <= sensor_data_i[DATA_W*i +: DATA_W];
    end
  end

  lighthouse_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (grant_fire),
    .pop       (pop),
    .flush     (flush),
    .push_data ({grant_idx, pending_data[grant_idx]}),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    overrun_ext = '0;
    overrun_ext[NUM_SENSORS-1:0] = overrun;
    count8 = 8'(fifo_count);
  end

  always_comb begin
    readdata = DEAD_BEEF;
    case (address)
      ADDR_DATA:    readdata = fifo_empty ? DEAD_BEEF : fifo_head[DATA_W-1:0];
      ADDR_HEAD_ID: readdata = fifo_empty ? '0 : {{(DATA_W-ID_W){1'b0}}, fifo_head[ENTRY_W-1:DATA_W]};
      ADDR_STATUS:  readdata = pack_status(overrun_ext, underflow, fifo_full, fifo_empty, count8);
      ADDR_MASK:    readdata = {16'b0, mask};
      ADDR_CTRL:    readdata = '0;
      default:      readdata = DEAD_BEEF;
    endcase
  end

endmodule

// File: tb/tb_lighthouse_sample_arbiter.sv
// Scoreboard bench: reads queue their expected readdata (from a queue-based
// reference model or fixed values); a monitor compares as the DUT answers.
module tb_lighthouse_sample_arbiter;
  import lighthouse_sample_arbiter_pkg::*;

  localparam int NS    = 9;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic               clock;
  logic               reset;
  logic [2:0]         address;
  logic               write;
  logic [31:0]        writedata;
  logic               read;
  logic [31:0]        readdata;
  logic               waitrequest;
  logic [NS*32-1:0]   sensor_data_i;
  logic [NS-1:0]      sensor_valid_i;

  lighthouse_sample_arbiter #(
    .NUM_SENSORS (NS),
    .FIFO_DEPTH  (DEPTH),
    .CNT_W       (CW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .address        (address),
    .write          (write),
    .writedata      (writedata),
    .read           (read),
    .readdata       (readdata),
    .waitrequest    (waitrequest),
    .sensor_data_i  (sensor_data_i),
    .sensor_valid_i (sensor_valid_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] val;
    logic [2:0]  addr;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: a plain queue for the FIFO plus per-sensor mailboxes.
  logic [35:0] m_q[$];
  logic [15:0] m_pend;
  logic [31:0] m_pdata [16];
  logic [15:0] m_ovr;
  logic        m_und;
  logic [15:0] m_mask;
  int          m_last;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    int n;
    n = m_q.size();
    case (a)
      3'd0: r = (n == 0) ? 32'hDEAD_BEEF : m_q[0][31:0];
      3'd1: r = (n == 0) ? 32'h0 : {28'h0, m_q[0][35:32]};
      3'd2: r = {m_ovr, m_und, (n == DEPTH), (n == 0), 5'b0, 8'(n)};
      3'd3: r = {16'h0, m_mask};
      3'd4: r = 32'h0;
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  task automatic model_step();
    bit pop_now, flush_now, clr_now;
    int g, c;
    if (reset) begin
      m_q.delete();
      m_pend = '0;
      m_ovr  = '0;
      m_und  = 1'b0;
      m_mask = 16'((1 << NS) - 1);
      m_last = NS - 1;
    end else begin
      pop_now   = read && address == 3'd0 && m_q.size() > 0;
      flush_now = write && address == 3'd4 && writedata[0];
      clr_now   = write && address == 3'd4 && writedata[1];
      if (clr_now) begin
        m_ovr = '0;
        m_und = 1'b0;
      end
      if (read && address == 3'd0 && m_q.size() == 0) m_und = 1'b1;
      g = -1;
      if (!flush_now && (m_q.size() < DEPTH || pop_now)) begin
        for (int k = 1; k <= NS; k++) begin
          c = (m_last + k) % NS;
          if (g < 0 && m_pend[c]) g = c;
        end
      end
      if (pop_now) void'(m_q.pop_front());
      if (g >= 0) begin
        m_q.push_back({4'(g), m_pdata[g]});
        m_pend[g] = 1'b0;
        m_last = g;
      end
      if (flush_now) m_q.delete();
      for (int i = 0; i < NS; i++) begin
        if (sensor_valid_i[i] && m_mask[i]) begin
          if (m_pend[i]) m_ovr[i] = 1'b1;
          m_pend[i]  = 1'b1;
          m_pdata[i] = sensor_data_i[32*i +: 32];
        end
      end
      if (write && address == 3'd3) begin
        for (int i = 0; i < NS; i++) if (!writedata[i]) m_pend[i] = 1'b0;
        m_mask = writedata[15:0];
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Monitor: readdata is combinational, so sample mid-cycle after inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (read === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL no_expectation addr=%0d got=%h", address, readdata);
        end else begin
          e = exp_q.pop_front();
          if (readdata !== e.val) begin
            bad++;
            $display("FAIL %s addr=%0d got=%h want=%h", e.name, e.addr, readdata, e.val);
          end
        end
        total++;
        if (waitrequest !== 1'b0) begin
          bad++;
          $display("FAIL waitrequest got=%b want=0", waitrequest);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic rd, input logic wr, input logic [2:0] a,
                      input logic [31:0] wd, input logic [NS-1:0] v, input logic [NS*32-1:0] d,
                      input bit use_const, input logic [31:0] cval, input string nm);
    exp_t e;
    @(negedge clock);
    reset = rst;
    read = rd;
    write = wr;
    address = a;
    writedata = wd;
    sensor_valid_i = v;
    sensor_data_i = d;
    if (rd) begin
      e.addr = a;
      e.name = nm;
      e.val  = use_const ? cval : model_read(a);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 3'd0, 32'h0, '0, '0, 0, 32'h0, "idle");
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1, 0, 0, 3'd0, 32'h0, '0, '0, 0, 32'h0, "reset");
  endtask

  task automatic rd_m(input logic [2:0] a);
    step(0, 1, 0, a, 32'h0, '0, '0, 0, 32'h0, "model_read");
  endtask

  task automatic rd_c(input logic [2:0] a, input logic [31:0] val, input string nm);
    step(0, 1, 0, a, 32'h0, '0, '0, 1, val, nm);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    step(0, 0, 1, a, wd, '0, '0, 0, 32'h0, "write");
  endtask

  task automatic pulse(input logic [NS-1:0] v, input logic [NS*32-1:0] d);
    step(0, 0, 0, 3'd0, 32'h0, v, d, 0, 32'h0, "pulse");
  endtask

  function automatic logic [NS*32-1:0] dv(input logic [31:0] base);
    logic [NS*32-1:0] r;
    for (int i = 0; i < NS; i++) r[32*i +: 32] = base + 32'(i);
    return r;
  endfunction

  initial begin
    logic [NS*32-1:0] d;
    logic [NS-1:0]    v;
    logic [31:0]      wd;
    logic [2:0]       a;
    logic             r, w, rs;
    int               vp;

    reset = 1'b1;
    read = 1'b0;
    write = 1'b0;
    address = 3'd0;
    writedata = 32'h0;
    sensor_valid_i = '0;
    sensor_data_i = '0;
    do_reset(2);

    // Reset state and empty-read behaviour
    rd_c(3'd0, 32'hDEAD_BEEF, "t1_data_empty");
    rd_c(3'd2, 32'h0000_A000, "t1_status_underflow");
    rd_c(3'd3, 32'h0000_01FF, "t1_mask_reset");
    rd_c(3'd1, 32'h0, "t1_id_empty");
    rd_c(3'd4, 32'h0, "t1_ctrl_reads0");
    rd_c(3'd6, 32'hDEAD_BEEF, "t1_unmapped");

    // Simultaneous pulses drain in round-robin order starting at sensor 0
    do_reset(1);
    d = '0;
    d[31:0] = 32'h11;
    d[127:96] = 32'h33;
    d[287:256] = 32'h88;
    pulse(9'h109, d);
    idle(3);
    rd_c(3'd2, 32'h0000_0003, "t2_count");
    rd_c(3'd1, 32'd0, "t2_id0");
    rd_c(3'd0, 32'h11, "t2_data0");
    rd_c(3'd1, 32'd3, "t2_id3");
    rd_c(3'd0, 32'h33, "t2_data3");
    rd_c(3'd1, 32'd8, "t2_id8");
    rd_c(3'd0, 32'h88, "t2_data8");

    // Fill to full, overrun sensor 2, then pop+push while full
    do_reset(1);
    for (int k = 0; k < DEPTH; k++) begin
      v = '0;
      v[k % NS] = 1'b1;
      pulse(v, dv(32'h3000_0000 + 32'(k * 16)));
    end
    idle(2);
    pulse(9'h004, dv(32'hA000));
    pulse(9'h004, dv(32'hB000));
    idle(1);
    rd_c(3'd2, 32'h0004_4010, "t3_full_overrun");
    rd_c(3'd0, 32'h3000_0000, "t3_pop_head");
    rd_c(3'd2, 32'h0004_4010, "t4_count_held");
    for (int k = 0; k < DEPTH; k++) rd_m(3'd0);
    rd_m(3'd2);

    // Mask gates capture; flush+clear in one write
    do_reset(1);
    rd_c(3'd0, 32'hDEAD_BEEF, "t5_underflow_read");
    wr(3'd3, 32'h0000_0001);
    pulse(9'h003, dv(32'h5000));
    idle(2);
    rd_c(3'd2, 32'h0000_8001, "t5_only_one");
    rd_c(3'd1, 32'd0, "t5_id0");
    rd_c(3'd3, 32'h0000_0001, "t5_mask_rb");
    wr(3'd4, 32'h0000_0003);
    rd_c(3'd2, 32'h0000_2000, "t5_flush_clear");

    // Mid-operation reset with queued entries and pending bits
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      v = '0;
      v[k] = 1'b1;
      pulse(v, dv(32'h4000));
    end
    pulse(9'h060, dv(32'h4100));
    do_reset(1);
    rd_c(3'd2, 32'h0000_2000, "t6_status_after_reset");
    pulse(9'h1FF, dv(32'h6000));
    idle(1);
    rd_c(3'd1, 32'd0, "t6_first_id");
    rd_c(3'd0, 32'h6000, "t6_first_data");

    // Randomized traffic checked against the reference model
    for (int c = 0; c < 3000; c++) begin
      vp = (c < 1500) ? 12 : 3;
      rs = ($urandom_range(0, 399) == 0);
      r  = ($urandom_range(0, 99) < 55);
      w  = !r && ($urandom_range(0, 99) < 6);
      if (r)
        a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
          : (($urandom_range(0, 2) == 0) ? 3'd2 : 3'd0);
      else if (w)
        a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7))
          : (($urandom_range(0, 1) == 1) ? 3'd3 : 3'd4);
      else
        a = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (w && a == 3'd4 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
      if (w && a == 3'd3) wd[15:0] = wd[15:0] | 16'($urandom);
      for (int i = 0; i < NS; i++) begin
        v[i] = ($urandom_range(0, 99) < vp);
        d[32*i +: 32] = $urandom;
      end
      step(rs, r, w, a, wd, v, d, 0, 32'h0, "rand");
    end

    idle(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
